// File: rtl/query_patch_streamer_if.sv
// Valid/ready patch stream from the query patch streamer to the compute pipeline.
interface query_patch_streamer_if #(
  parameter int PW = 55,
  parameter int IW = 10
) ();
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_patch;
  logic [IW-1:0] out_idx;
  logic          out_last;

  modport master (output out_valid, out_patch, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_patch, out_idx, out_last, output out_ready);
endinterface

// File: rtl/query_patch_streamer.sv
// Reads a burst of query patches from the patch SRAM and streams them out in order;
// a credit-checked skid FIFO absorbs fixed-latency SRAM returns under backpressure.
module query_patch_streamer #(
  parameter int DATA_WIDTH   = 11,
  parameter int PATCH_SIZE   = 5,
  parameter int ADDR_WIDTH   = 9,
  parameter int DEPTH        = 512,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int PW = DATA_WIDTH * PATCH_SIZE,
  localparam int IW = ADDR_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  input  logic [IW-1:0]          num_patches,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_csb1,
  output logic [ADDR_WIDTH-1:0]  mem_addr1,
  input  logic [PW-1:0]          mem_rpatch1,
  query_patch_streamer_if.master stream
);

  localparam int OW   = $clog2(FIFO_DEPTH + READ_LATENCY + 1);
  localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [OW:0]           CREDIT_LIM = (OW+1)'(FIFO_DEPTH);
  localparam logic [PTRW-1:0]       PTR_LAST   = PTRW'(FIFO_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0]   rd_addr, last_addr;
  logic [IW-1:0]           len, issued, delivered;
  logic [READ_LATENCY-1:0] vld_p;
  logic [OW-1:0]           count, inflight;
  logic [PTRW-1:0]         wptr, rptr;
  logic [PW-1:0]           fifo_mem [FIFO_DEPTH];
  logic accept, issue, done_nxt, tail, valid, hs, push, pop, last_hit, fifo_nonempty;

  function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_LAST) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + OW'(vld_p[i]);
  end

  assign tail          = vld_p[READ_LATENCY-1];
  assign fifo_nonempty = (count != '0);
  assign last_hit      = (delivered == len - 1'b1);
  assign valid         = fifo_nonempty | tail;
  assign hs            = valid & stream.out_ready;
  // An empty FIFO lets the returning patch fall straight through; it is only stored if not taken.
  assign push          = tail & ~(~fifo_nonempty & hs);
  assign pop           = hs & fifo_nonempty;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (num_patches != '0) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          done_nxt  = 1'b1;
        end
      end
      RUN: begin
        issue = (issued < len) && (({1'b0, count} + {1'b0, inflight}) < CREDIT_LIM);
        if (issued == len) state_nxt = DRAIN;
      end
      DRAIN: if (hs && last_hit) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Issue stage: request address and read-credit bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      last_addr <= '0;
      len       <= '0;
      issued    <= '0;
      delivered <= '0;
      vld_p     <= '0;
      count     <= '0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      vld_p[0] <= issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      if (accept) begin
        rd_addr   <= start_addr;
        len       <= num_patches;
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (issue) begin
          rd_addr   <= addr_inc(rd_addr);
          last_addr <= rd_addr;
          issued    <= issued + 1'b1;
        end
        if (hs) delivered <= delivered + 1'b1;
      end
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Return stage: SRAM data lands in the skid FIFO when the valid pipe tail is set
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= mem_rpatch1;
  end

  assign busy             = (state != IDLE);
  assign mem_csb1         = ~issue;
  assign mem_addr1        = issue ? rd_addr : last_addr;
  assign stream.out_valid = valid;
  assign stream.out_patch = fifo_nonempty ? fifo_mem[rptr] : (tail ? mem_rpatch1 : '0);
  assign stream.out_idx   = delivered;
  assign stream.out_last  = valid & last_hit;

endmodule

// File: tb/tb_query_patch_streamer.sv
// Randomized bench for query_patch_streamer with an SRAM model and a burst-level reference.
module tb_query_patch_streamer;
  localparam int DATA_WIDTH = 11, PATCH_SIZE = 5, ADDR_WIDTH = 9, DEPTH = 512;
  localparam int READ_LATENCY = 2, FIFO_DEPTH = 4;
  localparam int PW = DATA_WIDTH * PATCH_SIZE, IW = ADDR_WIDTH + 1;

  logic                  clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [ADDR_WIDTH-1:0] start_addr = '0;
  logic [IW-1:0]         num_patches = '0;
  logic                  busy, done, mem_csb1;
  logic [ADDR_WIDTH-1:0] mem_addr1;
  logic [PW-1:0]         mem_rpatch1;

  query_patch_streamer_if #(.PW(PW), .IW(IW)) sif ();

  query_patch_streamer #(
    .DATA_WIDTH(DATA_WIDTH), .PATCH_SIZE(PATCH_SIZE), .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH), .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .num_patches(num_patches), .busy(busy), .done(done), .mem_csb1(mem_csb1),
    .mem_addr1(mem_addr1), .mem_rpatch1(mem_rpatch1), .stream(sif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: address sampled on the edge closing the request cycle, data READ_LATENCY cycles later
  logic [PW-1:0]         mem_arr [DEPTH];
  logic [ADDR_WIDTH-1:0] a_p1 = '0, a_p2 = '0;
  always @(posedge clk) begin
    if (!mem_csb1) a_p1 <= mem_addr1;
    a_p2 <= a_p1;
  end
  assign mem_rpatch1 = mem_arr[a_p2];

  int n_vec = 0, n_err = 0;
  int burst_seq = 0, burst_start = 0, burst_len = 0, s_cyc = 0;
  int seen_seq = 0, n_issued = 0, n_deliv = 0, first_issue = -1, first_valid = -1;
  int done_cyc = -1, done_cnt = 0, max_out = 0;
  bit got_done = 1'b0;
  int addr_log [$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_busy"},  64'(busy), 64'(0));
    check_eq({tag, "_done"},  64'(done), 64'(0));
    check_eq({tag, "_csb"},   64'(mem_csb1), 64'(1));
    check_eq({tag, "_addr"},  64'(mem_addr1), 64'(0));
    check_eq({tag, "_valid"}, 64'(sif.out_valid), 64'(0));
    check_eq({tag, "_patch"}, 64'(sif.out_patch), 64'(0));
    check_eq({tag, "_idx"},   64'(sif.out_idx), 64'(0));
    check_eq({tag, "_last"},  64'(sif.out_last), 64'(0));
  endtask

  // Burst-level reference: patch i of a burst is mem[(start+i) mod DEPTH], delivered in order.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (burst_seq != seen_seq) begin
        seen_seq = burst_seq; n_issued = 0; n_deliv = 0; first_issue = -1; first_valid = -1;
        done_cyc = -1; done_cnt = 0; max_out = 0; got_done = 1'b0; addr_log.delete();
      end
      if (rst_n) begin
        if (!mem_csb1) begin
          check_eq("extra_rd", 64'(n_issued < burst_len), 64'(1));
          check_eq("rd_addr", 64'(mem_addr1), 64'((burst_start + n_issued) % DEPTH));
          addr_log.push_back(int'(mem_addr1));
          if (first_issue < 0) first_issue = cyc;
          n_issued++;
        end
        if (n_issued - n_deliv > max_out) max_out = n_issued - n_deliv;
        if (sif.out_valid) begin
          if (first_valid < 0) first_valid = cyc;
          check_eq("valid_ok", 64'(n_deliv < burst_len), 64'(1));
          if (n_deliv < burst_len) begin
            check_eq("patch", 64'(sif.out_patch), 64'(mem_arr[(burst_start + n_deliv) % DEPTH]));
            check_eq("idx", 64'(sif.out_idx), 64'(n_deliv));
            check_eq("last", 64'(sif.out_last), 64'(n_deliv == burst_len - 1));
          end
          if (sif.out_ready) n_deliv++;
        end
        if (done) begin
          check_eq("done_once", 64'(done_cnt), 64'(0));
          check_eq("done_count", 64'(n_deliv), 64'(burst_len));
          check_eq("done_busy", 64'(busy), 64'(0));
          done_cnt++;
          got_done = 1'b1;
          done_cyc = cyc;
        end
      end
    end
  endtask

  task automatic begin_burst(input int a, input int n);
    burst_start = a; burst_len = n; burst_seq++;
    start = 1'b1; start_addr = ADDR_WIDTH'(a); num_patches = IW'(n); s_cyc = cyc;
  endtask

  // mode 0: ready high; 1: random 50%; 2: ready low for 10 cycles, then high
  task automatic run_burst(input int a, input int n, input int mode, input bit spurious);
    int k;
    @(posedge clk); #1;
    begin_burst(a, n);
    sif.out_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    @(negedge clk); #1;
    k = 1;
    while (!got_done && k < n * 6 + 40) begin
      @(posedge clk); #1;
      start       = spurious && (k == 3);
      start_addr  = ADDR_WIDTH'($urandom);
      num_patches = spurious ? IW'(5) : IW'($urandom_range(0, DEPTH));
      case (mode)
        0:       sif.out_ready = 1'b1;
        1:       sif.out_ready = 1'($urandom_range(0, 1));
        default: sif.out_ready = (k >= 10);
      endcase
      @(negedge clk); #1;
      if (mode == 2 && k == 9) check_eq("stall_reads", 64'(n_issued), 64'(4));
      k++;
    end
    start = 1'b0;
    check_eq("done_seen", 64'(got_done), 64'(1));
    check_eq("delivered", 64'(n_deliv), 64'(n));
    check_eq("max_outstanding", 64'(max_out <= FIFO_DEPTH), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_wrap [4];
    bit found;
    exp_wrap = '{510, 511, 0, 1};
    for (int i = 0; i < DEPTH; i++) mem_arr[i] = PW'({$urandom(), $urandom()});
    sif.out_ready = 1'b0;
    fork monitor(); join_none

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_burst(0, 8, 0, 1'b0);
    check_eq("t1_first_rd", 64'(first_issue), 64'(s_cyc + 1));
    check_eq("t1_first_valid", 64'(first_valid), 64'(s_cyc + 3));
    check_eq("t1_done_cyc", 64'(done_cyc), 64'(s_cyc + 11));

    run_burst(510, 4, 0, 1'b0);
    check_eq("wrap_count", 64'(addr_log.size()), 64'(4));
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check_eq("wrap_addr", 64'(addr_log[i]), 64'(exp_wrap[i]));

    run_burst(37, 8, 2, 1'b0);
    run_burst(int'($urandom_range(0, DEPTH - 1)), DEPTH, 1, 1'b0);

    run_burst(5, 0, 0, 1'b0);
    check_eq("zero_done_cyc", 64'(done_cyc), 64'(s_cyc + 1));
    check_eq("zero_reads", 64'(n_issued), 64'(0));
    run_burst(200, 6, 0, 1'b1);

    @(posedge clk); #1;
    begin_burst(100, 10);
    sif.out_ready = 1'b1;
    @(negedge clk); #1;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
      if (sif.out_valid && sif.out_idx == IW'(3)) found = 1'b1;
    end
    check_eq("rst_trigger", 64'(found), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("post_rst_valid", 64'(sif.out_valid), 64'(0));
    check_eq("post_rst_busy", 64'(busy), 64'(0));
    run_burst(300, 12, 1, 1'b0);

    for (int b = 0; b < 4; b++)
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
